// File: rtl/sys_array_result_streamer.sv
// sys_array_result_streamer
// Captures a flat ROWS x COLS result matrix from the systolic array in one
// cycle, then streams it element by element in row-major order over a
// valid/ready interface. A one-cycle done pulse follows the final element.
// Optional feature macro: STREAMER_CHECKSUM_EN adds a running XOR checksum
// output over the elements transferred since the last capture.
module sys_array_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 5,
  parameter int COLS       = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load,
  input  logic [ROWS*COLS*2*DATA_WIDTH-1:0]     in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [2*DATA_WIDTH-1:0]               out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                                  out_last,
  output logic                                  done
`ifdef STREAMER_CHECKSUM_EN
  ,
  output logic [2*DATA_WIDTH-1:0]               checksum
`endif
);

  localparam int EW    = 2 * DATA_WIDTH;
  localparam int NELEM = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IDX_W = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [NELEM*EW-1:0]  r_buf;
  logic [ROW_W-1:0]     r_row;
  logic [COL_W-1:0]     r_col;
  logic [IDX_W-1:0]     r_idx;
  logic [EW-1:0]        r_data;
  logic                 r_last;

  logic                 w_capture;
  logic                 w_xfer;
  logic [ROW_W-1:0]     w_nxt_row;
  logic [COL_W-1:0]     w_nxt_col;
  logic [IDX_W-1:0]     w_nxt_idx;
  logic [EW-1:0]        w_nxt_data;
  logic                 w_nxt_last;

  // State register; reset abandons any stream in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, capture/transfer strobes and state-decoded handshake outputs.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (load) begin
          w_capture    = 1'b1;
          w_next_state = ST_STREAM;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_last) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_STREAM;
          end
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Row-major successor of the current element, used to preload the output register.
  always_comb begin
    w_nxt_row  = r_row;
    w_nxt_col  = r_col + COL_W'(1);
    w_nxt_idx  = r_idx + IDX_W'(1);
    w_nxt_data = '0;
    if (r_col == LAST_COL) begin
      w_nxt_col = '0;
      w_nxt_row = r_row + ROW_W'(1);
    end else begin
      w_nxt_row = r_row;
    end
    w_nxt_last = (w_nxt_row == LAST_ROW) && (w_nxt_col == LAST_COL);
    // The successor index runs past the buffer only after the last element.
    if (r_last) begin
      w_nxt_data = '0;
    end else begin
      w_nxt_data = r_buf[int'(w_nxt_idx)*EW +: EW];
    end
  end

  // Matrix buffer: written only by an IDLE capture, never cleared.
  always_ff @(posedge clk) begin
    if (w_capture && !reset) begin
      r_buf <= in_data;
    end else begin
      r_buf <= r_buf;
    end
  end

  // Output element registers; they read as zero whenever nothing is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_idx  <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_capture) begin
      r_row  <= '0;
      r_col  <= '0;
      r_idx  <= '0;
      r_data <= in_data[EW-1:0];
      r_last <= (NELEM == 1) ? 1'b1 : 1'b0;
    end else if (w_xfer) begin
      if (r_last) begin
        r_row  <= '0;
        r_col  <= '0;
        r_idx  <= '0;
        r_data <= '0;
        r_last <= 1'b0;
      end else begin
        r_row  <= w_nxt_row;
        r_col  <= w_nxt_col;
        r_idx  <= w_nxt_idx;
        r_data <= w_nxt_data;
        r_last <= w_nxt_last;
      end
    end else begin
      r_row  <= r_row;
      r_col  <= r_col;
      r_idx  <= r_idx;
      r_data <= r_data;
      r_last <= r_last;
    end
  end

  assign out_data = r_data;
  assign out_row  = r_row;
  assign out_col  = r_col;
  assign out_last = r_last;

`ifdef STREAMER_CHECKSUM_EN
  logic [EW-1:0] r_checksum;

  // Running XOR of accepted elements, restarted by every capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_capture) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ r_data;
    end else begin
      r_checksum <= r_checksum;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Self-checking bench for sys_array_result_streamer: a 2x3 instance driven by
// a directed sequence with a scoreboard of expected elements, plus a 1x1
// instance for the single-element corner case.
module tb_sys_array_result_streamer;

  localparam int DW = 8;
  localparam int EW = 16;
  localparam int AR = 2;
  localparam int AC = 3;
  localparam int AN = AR * AC;

  logic clk;
  logic reset;

  logic            a_load, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_done;
  logic [AN*EW-1:0] a_in_data;
  logic [EW-1:0]   a_out_data;
  logic [0:0]      a_out_row;
  logic [1:0]      a_out_col;

  logic            b_load, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_done;
  logic [EW-1:0]   b_in_data;
  logic [EW-1:0]   b_out_data;
  logic [0:0]      b_out_row;
  logic [0:0]      b_out_col;

`ifdef STREAMER_CHECKSUM_EN
  logic [EW-1:0]   a_checksum;
  logic [EW-1:0]   b_checksum;
`endif

  typedef struct packed {
    logic [EW-1:0] data;
    logic [0:0]    row;
    logic [1:0]    col;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   a_done_cnt = 0;

  logic [AN*EW-1:0] m1;
  logic [AN*EW-1:0] m2;

  sys_array_result_streamer #(.DATA_WIDTH(DW), .ROWS(AR), .COLS(AC)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .load      (a_load),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_row   (a_out_row),
    .out_col   (a_out_col),
    .out_last  (a_out_last),
    .done      (a_done)
`ifdef STREAMER_CHECKSUM_EN
    ,
    .checksum  (a_checksum)
`endif
  );

  sys_array_result_streamer #(.DATA_WIDTH(DW), .ROWS(1), .COLS(1)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .load      (b_load),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_row   (b_out_row),
    .out_col   (b_out_col),
    .out_last  (b_out_last),
    .done      (b_done)
`ifdef STREAMER_CHECKSUM_EN
    ,
    .checksum  (b_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] xor_all(input logic [AN*EW-1:0] m);
    logic [EW-1:0] x;
    x = '0;
    for (int k = 0; k < AN; k++) x = x ^ m[k*EW +: EW];
    return x;
  endfunction

  task automatic push_matrix(input logic [AN*EW-1:0] m);
    exp_t e;
    for (int k = 0; k < AN; k++) begin
      e.data = m[k*EW +: EW];
      e.row  = 1'(k / AC);
      e.col  = 2'(k % AC);
      e.last = (k == AN - 1);
      sb.push_back(e);
    end
  endtask

  // Capture a matrix on instance A; returns one cycle after the capture edge.
  task automatic load_a(input logic [AN*EW-1:0] m);
    a_in_data = m;
    a_load    = 1'b1;
    push_matrix(m);
    tick();
    a_load    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!a_done && cycles < budget) begin
      tick();
      cycles++;
    end
    check("a_done_seen", 64'(a_done), 64'd1);
  endtask

  // Scoreboard monitor for instance A, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_out_valid) begin
        check("a_in_ready_busy", 64'(a_in_ready), 64'd0);
        if (a_out_ready) begin
          check("a_sb_nonempty", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("a_out_data", 64'(a_out_data), 64'(e.data));
            check("a_out_row",  64'(a_out_row),  64'(e.row));
            check("a_out_col",  64'(a_out_col),  64'(e.col));
            check("a_out_last", 64'(a_out_last), 64'(e.last));
          end
        end
      end else begin
        check("a_invalid_zero", 64'({a_out_data, a_out_row, a_out_col, a_out_last}), 64'd0);
      end
    end
  end

  // Count done pulses on instance A.
  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int dc;
    for (int k = 0; k < AN; k++) begin
      m1[k*EW +: EW] = 16'(k) * 16'h0101;
      m2[k*EW +: EW] = 16'hA000 + 16'(k) * 16'h0011 + 16'(k * k);
    end
    reset = 1'b1;
    a_load = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
    b_load = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_a_in_ready",  64'(a_in_ready),  64'd1);
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_done",      64'(a_done),      64'd0);
    check("rst_a_last",      64'(a_out_last),  64'd0);
    check("rst_b_in_ready",  64'(b_in_ready),  64'd1);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);

    // Full matrix with sink always ready: 6 back-to-back elements then done.
    dc = a_done_cnt;
    load_a(m1);
    check("t1_first_valid", 64'(a_out_valid), 64'd1);
    wait_done(20, c);
    check("t1_cycles", 64'(c), 64'd6);
    check("t1_valid_at_done", 64'(a_out_valid), 64'd0);
`ifdef STREAMER_CHECKSUM_EN
    check("t1_checksum", 64'(a_checksum), 64'h0101);
`endif
    tick();
    check("t1_done_clear", 64'(a_done), 64'd0);
    check("t1_in_ready", 64'(a_in_ready), 64'd1);
    check("t1_done_count", 64'(a_done_cnt - dc), 64'd1);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure while element 2 is presented.
    load_a(m1);
    tick();
    tick();
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_data",  64'(a_out_data),  64'h0202);
      check("t2_hold_row",   64'(a_out_row),   64'd0);
      check("t2_hold_col",   64'(a_out_col),   64'd2);
      check("t2_hold_valid", 64'(a_out_valid), 64'd1);
      tick();
    end
    check("t2_hold_data4", 64'(a_out_data), 64'h0202);
    check("t2_hold_col4",  64'(a_out_col),  64'd2);
    a_out_ready = 1'b1;
    wait_done(20, c);
    check("t2_cycles", 64'(c), 64'd4);
`ifdef STREAMER_CHECKSUM_EN
    check("t2_checksum", 64'(a_checksum), 64'(xor_all(m1)));
`endif
    tick();
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Load pulsed mid-stream with other data is ignored.
    load_a(m1);
    tick();
    a_in_data = m2;
    a_load = 1'b1;
    tick();
    check("t3_in_ready_busy", 64'(a_in_ready), 64'd0);
    tick();
    a_load = 1'b0;
    wait_done(20, c);
    check("t3_cycles", 64'(c), 64'd3);
    tick();
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    check("t3_in_ready", 64'(a_in_ready), 64'd1);

    // Reset after the third transfer abandons the stream.
    dc = a_done_cnt;
    load_a(m1);
    tick();
    tick();
    tick();
    check("t4_remaining", 64'(sb.size()), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("t4_valid_off",  64'(a_out_valid), 64'd0);
    check("t4_in_ready",   64'(a_in_ready),  64'd1);
    check("t4_no_done",    64'(a_done),      64'd0);
    tick();
    check("t4_no_done2",   64'(a_done),      64'd0);
    check("t4_done_count", 64'(a_done_cnt - dc), 64'd0);
    load_a(m2);
    check("t4_restart_row", 64'(a_out_row), 64'd0);
    check("t4_restart_col", 64'(a_out_col), 64'd0);
    wait_done(20, c);
    check("t4_cycles", 64'(c), 64'd6);
`ifdef STREAMER_CHECKSUM_EN
    check("t4_checksum", 64'(a_checksum), 64'(xor_all(m2)));
`endif
    tick();
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Single-element matrix on the 1x1 instance.
    b_in_data = 16'hBEEF;
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    check("t5_valid", 64'(b_out_valid), 64'd1);
    check("t5_data",  64'(b_out_data),  64'hBEEF);
    check("t5_last",  64'(b_out_last),  64'd1);
    check("t5_rowcol", 64'({b_out_row, b_out_col}), 64'd0);
    check("t5_in_ready_busy", 64'(b_in_ready), 64'd0);
    tick();
    check("t5_valid_off", 64'(b_out_valid), 64'd0);
    check("t5_done",      64'(b_done),      64'd1);
    check("t5_last_off",  64'(b_out_last),  64'd0);
`ifdef STREAMER_CHECKSUM_EN
    check("t5_checksum", 64'(b_checksum), 64'hBEEF);
`endif
    tick();
    check("t5_done_clear", 64'(b_done),     64'd0);
    check("t5_in_ready",   64'(b_in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
